pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline processor. It keeps a shadow copy of the EX, MEM and WB destination and control bits for every instruction. From that copy it generates load-use stalls, branch flushes and EX-stage forwarding selects. It also provides saturating stall and flush counters for performance debug. It sits beside the decoder: ID-stage decode results in, pipeline-register enables, flushes and forwarding mux selects out.

## Interface
Parameters:
- CNT_WIDTH, 16, width of the stall and flush counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- idValid  input  1  the IF/ID register holds a real instruction.
- idRs  input  5  rs field of the ID instruction.
- idRt  input  5  rt field of the ID instruction.
- idDst  input  5  destination register after the regDst mux (rd or rt).
- idUsesRs  input  1  the ID instruction reads rs.
- idUsesRt  input  1  the ID instruction reads rt (R-type, SW, BEQ).
- idRegWrite  input  1  decoder regWrite.
- idMemRead  input  1  decoder memRead.
- exBranchTaken  input  1  the branch in EX resolved taken this cycle.
- pcWrite  output  1  PC load enable.
- ifidWrite  output  1  IF/ID register load enable.
- ifidFlush  output  1  clear IF/ID to a bubble.
- idexFlush  output  1  clear ID/EX to a bubble.
- fwdA  output  2  EX operand A select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- fwdB  output  2  EX operand B select, same encoding as fwdA.
- stallCount  output  CNT_WIDTH  number of stall cycles, saturating.
- flushCount  output  CNT_WIDTH  number of taken-branch flush events, saturating.

## Operation
- Shadow stages EX, MEM and WB each hold {valid, rs, rt, dst, regWrite, memRead}.
- Every cycle the shadow pipeline advances: WB <= MEM, MEM <= EX.
- EX <= ID fields when idValid=1 and idexFlush=0; otherwise EX <= bubble. A bubble has valid=0 and all control bits 0.
- Load-use stall condition, loadUse:
  - EX.valid, EX.memRead and EX.regWrite are all 1, and EX.dst != 0;
  - and either (idUsesRs and idRs == EX.dst) or (idUsesRt and idRt == EX.dst);
  - and idValid = 1.
- When loadUse=1 and exBranchTaken=0: pcWrite=0, ifidWrite=0, idexFlush=1, ifidFlush=0, and stallCount increments.
- When exBranchTaken=1: pcWrite=1 (target selection is external), ifidFlush=1, idexFlush=1, and flushCount increments.
  - A branch taken at the same time as a load-use stall: the branch wins and the stall is suppressed, because the ID instruction is squashed anyway.
- Otherwise: pcWrite=1, ifidWrite=1, both flushes 0.
- Forwarding is computed per EX operand (EX.rs for fwdA, EX.rt for fwdB):
  - 10 if MEM.valid, MEM.regWrite, MEM.dst != 0 and MEM.dst equals the operand register;
  - else 01 if the same conditions hold for WB;
  - else 00.
  - MEM has priority over WB. Register 0 is never forwarded.
- Counters saturate at all-ones and never wrap.

## Timing
- All outputs except the counters are combinational from the shadow state plus the current inputs; they settle in the same cycle.
- Counters update at the edge that ends the counted cycle and are visible one cycle later.
- A load-use hazard costs exactly 1 stall cycle. In the next cycle the load is in MEM and the stall condition clears. One cycle after that the dependent instruction is in EX with the load in WB, and forwarding selects 01.
- A taken branch costs exactly 2 bubbles (the IF/ID and ID/EX contents).
- Reset: every shadow stage becomes a bubble and both counters become 0. Outputs after reset: pcWrite=1, ifidWrite=1, ifidFlush=0, idexFlush=0, fwdA=00, fwdB=00.
- Reset asserted during a stall or flush aborts it at the same edge. No hazard state survives reset.

## Structure
- Forwarding codes `FWD_NONE, `FWD_EXMEM and `FWD_MEMWB, plus `FwdPath, go in Types.v.
- The shadow stage record type also goes in Types.v.
- One sub-module: hazard_shadow_stage, a single registered {valid, rs, rt, dst, regWrite, memRead} stage with synchronous clear. It is instantiated three times.

## Test plan
- **Reset:** assert rst for 2 cycles -> pcWrite=1, ifidWrite=1, fwdA=fwdB=00, both counters 0.
- **Load-use:** `lw $2,0($1)` then `add $3,$2,$4` -> exactly one cycle with pcWrite=0, ifidWrite=0, idexFlush=1; next cycle no stall; following cycle fwdA=01; stallCount=1.
- **Back-to-back forwarding:** `add $5,$1,$1`, `sub $6,$5,$5`, `or $7,$5,$6` -> sub in EX: fwdA=fwdB=10; or in EX: fwdA=01, fwdB=10.
- **Register zero:** `add $0,$1,$1` then `add $3,$0,$0` -> fwdA=fwdB=00. `lw $0` followed by a reader of $0 -> no stall.
- **Branch precedence:** exBranchTaken=1 in the same cycle as a load-use match -> ifidFlush=1, idexFlush=1, pcWrite=1; stallCount unchanged, flushCount +1.
- **Saturation and reset mid-stall:** preload via 65540 stall cycles -> stallCount holds 0xFFFF. Then assert rst during a stall -> next cycle counters 0 and pcWrite=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding select codes
// and the shadow-stage record mirroring one pipeline register's control bits.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_path_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_read;
    } shadow_stage_t;

    localparam int SHADOW_W = $bits(shadow_stage_t);
    localparam shadow_stage_t SHADOW_BUBBLE = '0;

    // True when the stage will write a non-zero register matching src.
    function automatic logic stage_supplies(input logic [4:0] src, input shadow_stage_t st);
        return st.valid && st.reg_write && (st.dst != 5'd0) && (st.dst == src);
    endfunction

    // The younger result (MEM) wins over the older one (WB).
    function automatic fwd_path_t fwd_select(input logic [4:0] src,
                                             input shadow_stage_t mem,
                                             input shadow_stage_t wb);
        fwd_path_t sel;
        sel = FWD_NONE;
        if (stage_supplies(src, mem)) begin
            sel = FWD_EXMEM;
        end else if (stage_supplies(src, wb)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_shadow_stage.sv
// One registered shadow stage {valid, rs, rt, dst, regWrite, memRead};
// a synchronous clear loads a bubble instead of the incoming record.
module hazard_shadow_stage
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic [SHADOW_W-1:0] stage_i,
    output logic [SHADOW_W-1:0] stage_o
);

    shadow_stage_t stage_q;
    shadow_stage_t stage_d;

    always_comb begin
        stage_d = shadow_stage_t'(stage_i);
        if (clear_i) begin
            stage_d = SHADOW_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= SHADOW_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, EX-stage forwarding selects and saturating perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idValid,
    input  logic [4:0]           idRs,
    input  logic [4:0]           idRt,
    input  logic [4:0]           idDst,
    input  logic                 idUsesRs,
    input  logic                 idUsesRt,
    input  logic                 idRegWrite,
    input  logic                 idMemRead,
    input  logic                 exBranchTaken,
    output logic                 pcWrite,
    output logic                 ifidWrite,
    output logic                 ifidFlush,
    output logic                 idexFlush,
    output logic [1:0]           fwdA,
    output logic [1:0]           fwdB,
    output logic [CNT_WIDTH-1:0] stallCount,
    output logic [CNT_WIDTH-1:0] flushCount
);

    shadow_stage_t id_rec;
    shadow_stage_t ex_rec;
    shadow_stage_t mem_rec;
    shadow_stage_t wb_rec;
    logic [SHADOW_W-1:0] ex_bits;
    logic [SHADOW_W-1:0] mem_bits;
    logic [SHADOW_W-1:0] wb_bits;

    logic load_use;
    logic stall_event;
    logic flush_event;
    logic ex_clear;

    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        id_rec           = SHADOW_BUBBLE;
        id_rec.valid     = 1'b1;
        id_rec.rs        = idRs;
        id_rec.rt        = idRt;
        id_rec.dst       = idDst;
        id_rec.reg_write = idRegWrite;
        id_rec.mem_read  = idMemRead;
    end

    // EX takes the decoded instruction unless it is absent or being squashed.
    assign ex_clear = !idValid || idexFlush;

    hazard_shadow_stage u_ex_stage (
        .clk     (clk),
        .rst     (rst),
        .clear_i (ex_clear),
        .stage_i (id_rec),
        .stage_o (ex_bits)
    );

    hazard_shadow_stage u_mem_stage (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .stage_i (ex_bits),
        .stage_o (mem_bits)
    );

    hazard_shadow_stage u_wb_stage (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .stage_i (mem_bits),
        .stage_o (wb_bits)
    );

    assign ex_rec  = shadow_stage_t'(ex_bits);
    assign mem_rec = shadow_stage_t'(mem_bits);
    assign wb_rec  = shadow_stage_t'(wb_bits);

    always_comb begin
        load_use = 1'b0;
        if (idValid && ex_rec.valid && ex_rec.mem_read && ex_rec.reg_write &&
            (ex_rec.dst != 5'd0)) begin
            load_use = (idUsesRs && (idRs == ex_rec.dst)) ||
                       (idUsesRt && (idRt == ex_rec.dst));
        end
    end

    // A taken branch squashes the ID instruction, so it overrides any stall.
    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        stall_event = 1'b0;
        flush_event = 1'b0;
        if (exBranchTaken) begin
            ifidFlush   = 1'b1;
            idexFlush   = 1'b1;
            flush_event = 1'b1;
        end else if (load_use) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexFlush   = 1'b1;
            stall_event = 1'b1;
        end
    end

    assign fwdA = fwd_select(ex_rec.rs, mem_rec, wb_rec);
    assign fwdB = fwd_select(ex_rec.rt, mem_rec, wb_rec);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_event && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_event && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;

endmodule
